// File: rtl/full_adder_reg.sv
// Registered ripple-carry full adder: {cout, sum} = a + b + cin, one cycle late.
// A valid strobe rides alongside the data so results can be qualified downstream.
module full_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i])
                  | (a[i] & c[i])
                  | (b[i] & c[i]);
  end

  // Data holds when no operands arrive; only the strobe drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_adder_reg.sv
// Bench for full_adder_reg at WIDTH 1, 4 and 8 against an arithmetic model.
// Inputs change 1 time unit after each rising edge; outputs sampled then too.
module tb_full_adder_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv1, iv4, iv8;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       c1, c4, c8;

  logic [0:0] s1;
  logic [3:0] s4;
  logic [7:0] s8;
  logic       co1, co4, co8;
  logic       ov1, ov4, ov8;

  full_adder_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv1),
    .a(a1), .b(b1), .cin(c1),
    .sum(s1), .cout(co1), .out_valid(ov1)
  );

  full_adder_reg #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv4),
    .a(a4), .b(b4), .cin(c4),
    .sum(s4), .cout(co4), .out_valid(ov4)
  );

  full_adder_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8),
    .a(a8), .b(b8), .cin(c8),
    .sum(s8), .cout(co8), .out_valid(ov8)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model: full (WIDTH+1)-bit result and valid flag per instance
  logic [1:0] m1;
  logic [4:0] m4;
  logic [8:0] m8;
  logic       m1v, m4v, m8v;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    m1 = '0; m4 = '0; m8 = '0;
    m1v = 1'b0; m4v = 1'b0; m8v = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".w1"}, 64'({co1, s1}), 64'(m1));
    check({tag, ".w1v"}, 64'(ov1), 64'(m1v));
    check({tag, ".w4"}, 64'({co4, s4}), 64'(m4));
    check({tag, ".w4v"}, 64'(ov4), 64'(m4v));
    check({tag, ".w8"}, 64'({co8, s8}), 64'(m8));
    check({tag, ".w8v"}, 64'(ov8), 64'(m8v));
  endtask

  task automatic cycle(input string tag);
    int t;
    @(posedge clk);
    if (rst) begin
      clear_model();
    end else begin
      m1v = iv1; m4v = iv4; m8v = iv8;
      if (iv1) begin
        t = int'(a1) + int'(b1) + int'(c1);
        m1 = t[1:0];
      end
      if (iv4) begin
        t = int'(a4) + int'(b4) + int'(c4);
        m4 = t[4:0];
      end
      if (iv8) begin
        t = int'(a8) + int'(b8) + int'(c8);
        m8 = t[8:0];
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive_rand(input bit all_valid);
    a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
    a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    iv1 = all_valid | 1'($urandom);
    iv4 = all_valid | 1'($urandom);
    iv8 = all_valid | ($urandom_range(0, 7) != 0);
  endtask

  logic [7:0] tt_sum;
  logic [7:0] tt_cout;

  initial begin
    rst = 1'b1;
    iv1 = 0; iv4 = 0; iv8 = 0;
    a1 = 0; b1 = 0; c1 = 0;
    a4 = 0; b4 = 0; c4 = 0;
    a8 = 0; b8 = 0; c8 = 0;
    clear_model();
    cycle("reset");
    cycle("reset");
    rst = 1'b0;

    // exhaustive WIDTH=1 truth table, index = {a,b,cin}
    tt_sum  = 8'b1001_0110;
    tt_cout = 8'b1110_1000;
    for (int v = 0; v < 8; v++) begin
      {a1, b1, c1} = 3'(v);
      iv1 = 1'b1;
      cycle("tt");
      check("tt.sum", 64'(s1), 64'(tt_sum[v]));
      check("tt.cout", 64'(co1), 64'(tt_cout[v]));
      check("tt.valid", 64'(ov1), 64'd1);
    end

    // hold: data persists when in_valid drops
    a1 = 1; b1 = 1; c1 = 1; iv1 = 1;
    cycle("hold.load");
    a1 = 0; b1 = 0; c1 = 0; iv1 = 0;
    cycle("hold");
    check("hold.sum", 64'(s1), 64'd1);
    check("hold.cout", 64'(co1), 64'd1);
    check("hold.valid", 64'(ov1), 64'd0);

    // asynchronous reset mid-cycle
    #1;
    rst = 1'b1;
    #1;
    check("arst.sum", 64'(s1), 64'd0);
    check("arst.cout", 64'(co1), 64'd0);
    check("arst.valid", 64'(ov1), 64'd0);
    clear_model();
    a1 = 1; b1 = 1; c1 = 1; iv1 = 1;
    cycle("arst.hold");
    cycle("arst.hold");
    rst = 1'b0;
    iv1 = 0;

    // WIDTH=8 wrap cases
    a8 = 8'hFF; b8 = 8'h00; c8 = 1; iv8 = 1;
    cycle("wrap1");
    check("wrap1.sum", 64'(s8), 64'h00);
    check("wrap1.cout", 64'(co8), 64'd1);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1;
    cycle("wrap2");
    check("wrap2.sum", 64'(s8), 64'hFF);
    check("wrap2.cout", 64'(co8), 64'd1);

    // random back-to-back streams on all widths
    for (int i = 0; i < 1000; i++) begin
      drive_rand(i < 500);
      cycle("rand");
    end

    // reset arriving between operand setup and the capturing edge
    a4 = 4'h9; b4 = 4'h8; c4 = 0; iv4 = 1;
    #2;
    rst = 1'b1;
    #1;
    clear_model();
    check("mid.valid", 64'(ov4), 64'd0);
    check("mid.data", 64'({co4, s4}), 64'd0);
    cycle("mid.rst");
    rst = 1'b0;
    iv1 = 0; iv8 = 0;
    a4 = 4'h3; b4 = 4'h4; c4 = 1; iv4 = 1;
    cycle("mid.after");
    check("mid.after.data", 64'({co4, s4}), 64'h08);
    check("mid.after.valid", 64'(ov4), 64'd1);
    iv4 = 0;
    cycle("mid.drop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
